// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state encoding, opcode and ALU code constants for the multicycle control FSM
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        I_EXEC   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // States whose exit back to FETCH completes an instruction
    function automatic logic is_terminal(input state_t s);
        return (s == MEM_WB) || (s == MEM_WR) || (s == ALU_WB) || (s == BRANCH);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps state and funct fields to the ALU control code and R-type legality
module alu_decoder
    import mc_pkg::*;
(
    input  state_t      state,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [3:0]  alu_control,
    output logic        r_legal
);

    logic [3:0] r_op;

    always_comb begin
        r_legal = 1'b0;
        r_op    = ALU_ADD;
        case ({funct3, funct7_5})
            4'b0000: begin r_legal = 1'b1; r_op = ALU_ADD; end
            4'b0001: begin r_legal = 1'b1; r_op = ALU_SUB; end
            4'b1110: begin r_legal = 1'b1; r_op = ALU_AND; end
            4'b1100: begin r_legal = 1'b1; r_op = ALU_OR;  end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        if (state == R_EXEC)
            alu_control = r_op;
        else if (state == BRANCH)
            alu_control = ALU_SUB;
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM sequencing the shared multicycle RV32I-subset datapath
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        PCSource,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        RegWrite,
    output logic [3:0]  ALUControl,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    state_t     state_q;
    logic [3:0] dec_alu;
    logic       r_legal;

    alu_decoder u_alu_decoder (
        .state       (state_q),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu),
        .r_legal     (r_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            retired <= 32'd0;
        end else begin
            if (is_terminal(state_q))
                retired <= retired + 32'd1;
            case (state_q)
                FETCH:    state_q <= DECODE;
                DECODE: begin
                    if ((opcode == OP_LW || opcode == OP_SW) && funct3 == 3'b010)
                        state_q <= MEM_ADDR;
                    else if (opcode == OP_R && r_legal)
                        state_q <= R_EXEC;
                    else if (opcode == OP_ADDI && funct3 == 3'b000)
                        state_q <= I_EXEC;
                    else if (opcode == OP_BR)
                        state_q <= BRANCH;
                    else
                        state_q <= HALT;
                end
                MEM_ADDR: state_q <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   state_q <= MEM_WB;
                R_EXEC:   state_q <= ALU_WB;
                I_EXEC:   state_q <= ALU_WB;
                MEM_WB:   state_q <= FETCH;
                MEM_WR:   state_q <= FETCH;
                ALU_WB:   state_q <= FETCH;
                BRANCH:   state_q <= FETCH;
                default:  state_q <= HALT;
            endcase
        end
    end

    // Strobes are gated by reset combinationally so nothing fires while it is held
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        PCSource = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        RegWrite = 1'b0;
        illegal  = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                end
                DECODE:   ALUSrcB = 2'b10;
                MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
                MEM_RD:   begin MemRead = 1'b1; IorD = 1'b1; end
                MEM_WB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
                MEM_WR:   begin MemWrite = 1'b1; IorD = 1'b1; end
                R_EXEC:   ALUSrcA = 1'b1;
                I_EXEC:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
                ALU_WB:   RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA  = 1'b1;
                    PCSource = 1'b1;
                    PCWrite  = (funct3 == 3'b000) ? zero :
                               (funct3 == 3'b001) ? ~zero : 1'b0;
                end
                HALT:     illegal = 1'b1;
                default:  ;
            endcase
        end
    end

    assign ALUControl = reset ? dec_alu : ALU_ADD;
    assign state      = state_q;

endmodule
